rca_pipe: RTL

//   Parametrised, pipelined ripple-carry adder/subtractor. The WIDTH-bit carry chain is cut into

---
 rtl/rca_pipe.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/rca_pipe.sv
// rtl/rca_pipe.sv - pipelined ripple-carry adder/subtractor with valid/ready handshakes
//
// The WIDTH-bit carry chain is split into STAGES chunks of CHUNK = WIDTH/STAGES bits.
// Each stage adds one chunk and registers its carry for the next stage. Operands that
// later stages still need travel alongside in skew registers. Sum chunks that are
// already finished travel alongside in deskew registers. The whole pipe advances only
// when the output slot is empty or is being drained.
//
// Parameters:
//   WIDTH   operand/sum width in bits; must be a multiple of STAGES
//   STAGES  number of pipeline stages (latency in cycles), >= 1
//
// Ports:
//   clk, rst             clock (rising edge); asynchronous active-high reset
//   in_valid, in_ready   operand beat handshake
//   a, b, cin, sub       operands; sub=1 gives a-b and ignores cin
//   out_valid, out_ready result handshake
//   sum, cout            result and carry-out of bit WIDTH-1 (for sub, 1 means no borrow)
//   ovf                  signed overflow; this port exists only when RCA_PIPE_OVF_EN is defined
//
// Build option: define RCA_PIPE_OVF_EN to add the ovf output.

module rca_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef RCA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK = WIDTH / STAGES;

  generate
    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $fatal(1, "rca_pipe: WIDTH must be a multiple of STAGES and STAGES must be >= 1");
    end
  endgenerate

  // Per-stage registers. The operand registers of stage k hold the full operands,
  // but only the chunks above k are read by later stages.
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] creg;
  logic [WIDTH-1:0]  areg [STAGES];
  logic [WIDTH-1:0]  breg [STAGES];
  logic [WIDTH-1:0]  sreg [STAGES];

  logic              adv;
  logic [WIDTH-1:0]  bp;
  logic              c0;

  logic [WIDTH-1:0]  nxt_s [STAGES];
  logic [STAGES-1:0] nxt_c;
  logic [WIDTH-1:0]  src_a;
  logic [WIDTH-1:0]  src_b;
  logic [WIDTH-1:0]  src_s;
  logic              src_c;
  logic [CHUNK:0]    chunk_sum;

`ifdef RCA_PIPE_OVF_EN
  logic              nxt_ovf;
  logic              ovf_q;
`endif

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Subtraction is a + ~b + 1, so the inversion and the forced carry-in apply up front.
  assign bp = sub ? ~b : b;
  assign c0 = sub ? 1'b1 : cin;

  always_comb begin
    src_a     = '0;
    src_b     = '0;
    src_s     = '0;
    src_c     = 1'b0;
    chunk_sum = '0;
    nxt_c     = '0;
`ifdef RCA_PIPE_OVF_EN
    nxt_ovf   = 1'b0;
`endif
    for (int k = 0; k < STAGES; k++) begin
      nxt_s[k] = '0;
    end

    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        src_a = a;
        src_b = bp;
        src_s = '0;
        src_c = c0;
      end else begin
        src_a = areg[(k > 0) ? k - 1 : 0];
        src_b = breg[(k > 0) ? k - 1 : 0];
        src_s = sreg[(k > 0) ? k - 1 : 0];
        src_c = creg[(k > 0) ? k - 1 : 0];
      end
      chunk_sum = {1'b0, src_a[k*CHUNK +: CHUNK]}
                + {1'b0, src_b[k*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, src_c};
      nxt_s[k]                  = src_s;
      nxt_s[k][k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
      nxt_c[k]                  = chunk_sum[CHUNK];
`ifdef RCA_PIPE_OVF_EN
      // The carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c_in.
      if (k == STAGES - 1) begin
        nxt_ovf = src_a[WIDTH-1] ^ src_b[WIDTH-1] ^ chunk_sum[CHUNK-1] ^ chunk_sum[CHUNK];
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld  <= '0;
      creg <= '0;
      for (int k = 0; k < STAGES; k++) begin
        areg[k] <= '0;
        breg[k] <= '0;
        sreg[k] <= '0;
      end
`ifdef RCA_PIPE_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (adv) begin
      // When adv=1, in_ready=1, so stage 0 takes in_valid directly. A bubble enters as valid=0.
      for (int k = 0; k < STAGES; k++) begin
        if (k == 0) begin
          vld[k]  <= in_valid;
          areg[k] <= a;
          breg[k] <= bp;
        end else begin
          vld[k]  <= vld[(k > 0) ? k - 1 : 0];
          areg[k] <= areg[(k > 0) ? k - 1 : 0];
          breg[k] <= breg[(k > 0) ? k - 1 : 0];
        end
        sreg[k] <= nxt_s[k];
      end
      creg <= nxt_c;
`ifdef RCA_PIPE_OVF_EN
      ovf_q <= nxt_ovf;
`endif
    end
  end

  assign out_valid = vld[STAGES-1];
  assign sum       = sreg[STAGES-1];
  assign cout      = creg[STAGES-1];
`ifdef RCA_PIPE_OVF_EN
  assign ovf       = ovf_q;
`endif

  // The last stage's operand copies have no consumer.
  logic unused_skew;
  assign unused_skew = ^{areg[STAGES-1], breg[STAGES-1]};

endmodule
